// File: rtl/frame_unpacker.sv
// Frame unpacker: turns a strobed byte stream into 12-bit fast words and
// two-byte slow words, with inter-byte gap timeout that aborts partial frames.
module frame_unpacker #(
  parameter int FAST_BYTES = 16,
  parameter int SLOW_WORDS = 1,
  parameter int GAP_CYC    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  iData,
  input  logic        strob,
  input  logic        sEn,
  output logic [11:0] fData,
  output logic        fVal,
  output logic [11:0] sData,
  output logic        sVal,
  output logic [6:0]  sIdx,
  output logic        frameDone,
  output logic        frameErr
);

  localparam int TOTAL = FAST_BYTES + 2 * SLOW_WORDS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int GW    = $clog2(GAP_CYC + 1);
  localparam logic [CW-1:0] LAST_FAST = CW'(FAST_BYTES - 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(TOTAL - 1);
  localparam logic [CW-1:0] FAST_CNT  = CW'(FAST_BYTES);
  localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_CYC);

  typedef enum logic [1:0] {FAST, SLOW_LO, SLOW_HI} stateT;

  stateT          state, stateNext;
  logic [1:0]     sync;
  logic [CW-1:0]  count, countNext;
  logic [7:0]     temp, tempNext;
  logic [GW-1:0]  gap, gapNext;
  logic [11:0]    fDataNext, sDataNext;
  logic [6:0]     sIdxNext;
  logic           fValNext, sValNext, doneNext, errNext;
  logic           byteEv;
  logic [CW-1:0]  slowOff;

  // sync[0] is the newer sample; a byte event is its rising edge
  assign byteEv  = ~sync[1] & sync[0];
  assign slowOff = count - FAST_CNT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync      <= 2'b00;
      state     <= FAST;
      count     <= '0;
      temp      <= '0;
      gap       <= '0;
      fData     <= '0;
      sData     <= '0;
      sIdx      <= '0;
      fVal      <= 1'b0;
      sVal      <= 1'b0;
      frameDone <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      sync      <= {sync[0], strob};
      state     <= stateNext;
      count     <= countNext;
      temp      <= tempNext;
      gap       <= gapNext;
      fData     <= fDataNext;
      sData     <= sDataNext;
      sIdx      <= sIdxNext;
      fVal      <= fValNext;
      sVal      <= sValNext;
      frameDone <= doneNext;
      frameErr  <= errNext;
    end
  end

  always_comb begin
    stateNext = state;
    countNext = count;
    tempNext  = temp;
    gapNext   = gap;
    fDataNext = fData;
    sDataNext = sData;
    sIdxNext  = sIdx;
    fValNext  = 1'b0;
    sValNext  = 1'b0;
    doneNext  = 1'b0;
    errNext   = 1'b0;

    if (byteEv) begin
      // a byte arriving on the timeout cycle takes priority over the abort
      gapNext = '0;
      case (state)
        FAST: begin
          fDataNext = {1'b0, iData, 3'b000};
          fValNext  = 1'b1;
          if (count == LAST_FAST) begin
            if (SLOW_WORDS > 0) begin
              stateNext = SLOW_LO;
              countNext = count + 1'b1;
            end else begin
              countNext = '0;
              doneNext  = 1'b1;
            end
          end else begin
            countNext = count + 1'b1;
          end
        end
        SLOW_LO: begin
          tempNext  = iData;
          stateNext = SLOW_HI;
          countNext = count + 1'b1;
        end
        SLOW_HI: begin
          if (sEn) begin
            sDataNext = {1'b0, iData[1:0], temp, 1'b0};
            sIdxNext  = 7'(slowOff >> 1);
            sValNext  = 1'b1;
          end
          if (count == LAST_BYTE) begin
            stateNext = FAST;
            countNext = '0;
            doneNext  = 1'b1;
          end else begin
            stateNext = SLOW_LO;
            countNext = count + 1'b1;
          end
        end
        default: begin
          stateNext = FAST;
          countNext = '0;
        end
      endcase
    end else if (gap != GAP_MAX) begin
      gapNext = gap + 1'b1;
    end else if (count != '0) begin
      // gap counter stays saturated, so clearing count makes this fire once
      countNext = '0;
      tempNext  = '0;
      stateNext = FAST;
      errNext   = 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_unpacker.sv
// Directed bench for frame_unpacker: three parameterisations (default, two slow
// words, fast-only) driven with hand-computed byte sequences.
module tb_frame_unpacker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sEn = 1'b0;
  logic [2:0]       strob = 3'b000;
  logic [2:0][7:0]  iData = '0;
  logic [2:0][11:0] fData, sData;
  logic [2:0][6:0]  sIdx;
  logic [2:0]       fVal, sVal, frameDone, frameErr;

  int nAssert = 0;
  int nFail   = 0;
  int fCnt[3], sCnt[3], dCnt[3], eCnt[3], dWithS[3], dWithF[3];
  int baseF, baseD, baseS;

  always #5 clk = ~clk;

  frame_unpacker #(.FAST_BYTES(16), .SLOW_WORDS(1), .GAP_CYC(1024)) u0 (
    .clk(clk), .rst(rst), .iData(iData[0]), .strob(strob[0]), .sEn(sEn),
    .fData(fData[0]), .fVal(fVal[0]), .sData(sData[0]), .sVal(sVal[0]),
    .sIdx(sIdx[0]), .frameDone(frameDone[0]), .frameErr(frameErr[0]));

  frame_unpacker #(.FAST_BYTES(2), .SLOW_WORDS(2), .GAP_CYC(1024)) u1 (
    .clk(clk), .rst(rst), .iData(iData[1]), .strob(strob[1]), .sEn(sEn),
    .fData(fData[1]), .fVal(fVal[1]), .sData(sData[1]), .sVal(sVal[1]),
    .sIdx(sIdx[1]), .frameDone(frameDone[1]), .frameErr(frameErr[1]));

  frame_unpacker #(.FAST_BYTES(4), .SLOW_WORDS(0), .GAP_CYC(1024)) u2 (
    .clk(clk), .rst(rst), .iData(iData[2]), .strob(strob[2]), .sEn(sEn),
    .fData(fData[2]), .fVal(fVal[2]), .sData(sData[2]), .sVal(sVal[2]),
    .sIdx(sIdx[2]), .frameDone(frameDone[2]), .frameErr(frameErr[2]));

  // pulse counters, sampled mid-cycle
  initial begin
    for (int i = 0; i < 3; i++) begin
      fCnt[i] = 0; sCnt[i] = 0; dCnt[i] = 0; eCnt[i] = 0; dWithS[i] = 0; dWithF[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (fVal[i]) fCnt[i]++;
      if (sVal[i]) sCnt[i]++;
      if (frameDone[i]) dCnt[i]++;
      if (frameErr[i]) eCnt[i]++;
      if (frameDone[i] && sVal[i]) dWithS[i]++;
      if (frameDone[i] && fVal[i]) dWithF[i]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic sendByte(input int u, input logic [7:0] b, input int hold);
    @(negedge clk);
    iData[u] = b;
    strob[u] = 1'b1;
    repeat (hold) @(negedge clk);
    strob[u] = 1'b0;
    idle(3);
  endtask

  initial begin
    // reset state
    idle(3);
    check("rst_fData", 32'(fData[0]), 32'h0);
    check("rst_sData", 32'(sData[0]), 32'h0);
    check("rst_sIdx", 32'(sIdx[0]), 32'h0);
    check("rst_pulses", 32'({fVal[0], sVal[0], frameDone[0], frameErr[0]}), 32'h0);
    rst = 1'b1;
    idle(2);

    // latency of first fast byte: pulse one clk after the event cycle, one cycle wide
    @(negedge clk);
    iData[0] = 8'h00;
    strob[0] = 1'b1;
    @(negedge clk);
    check("lat_early", 32'(fVal[0]), 32'h0);
    @(negedge clk);
    check("lat_pulse", 32'(fVal[0]), 32'h1);
    @(negedge clk);
    check("lat_width", 32'(fVal[0]), 32'h0);
    strob[0] = 1'b0;
    idle(3);

    // default frame, sEn=1
    for (int i = 1; i < 16; i++) sendByte(0, 8'(i), 3);
    check("f16_cnt", 32'(fCnt[0]), 32'd16);
    check("f16_data", 32'(fData[0]), 32'h078);
    check("f16_nodone", 32'(dCnt[0]), 32'd0);
    sEn = 1'b1;
    sendByte(0, 8'hAB, 3);
    check("slo_nopulse", 32'(sCnt[0]), 32'd0);
    sendByte(0, 8'h03, 3);
    check("shi_data", 32'(sData[0]), 32'h756);
    check("shi_idx", 32'(sIdx[0]), 32'h0);
    check("shi_cnt", 32'(sCnt[0]), 32'd1);
    check("shi_done", 32'(dCnt[0]), 32'd1);
    check("shi_done_with_s", 32'(dWithS[0]), 32'd1);
    check("shi_fcnt", 32'(fCnt[0]), 32'd16);

    // same frame with sEn=0
    sEn = 1'b0;
    for (int i = 0; i < 16; i++) sendByte(0, 8'(i), 3);
    sendByte(0, 8'hAB, 3);
    sendByte(0, 8'h03, 3);
    check("sen0_fcnt", 32'(fCnt[0]), 32'd32);
    check("sen0_scnt", 32'(sCnt[0]), 32'd1);
    check("sen0_sdata", 32'(sData[0]), 32'h756);
    check("sen0_done", 32'(dCnt[0]), 32'd2);

    // two slow words (FAST_BYTES=2)
    sEn = 1'b1;
    sendByte(1, 8'h01, 3);
    sendByte(1, 8'h02, 3);
    sendByte(1, 8'h11, 3);
    sendByte(1, 8'h01, 3);
    check("sw2_w0_data", 32'(sData[1]), 32'h222);
    check("sw2_w0_idx", 32'(sIdx[1]), 32'h0);
    check("sw2_w0_nodone", 32'(dCnt[1]), 32'd0);
    sendByte(1, 8'h22, 3);
    sendByte(1, 8'h02, 3);
    check("sw2_w1_data", 32'(sData[1]), 32'h444);
    check("sw2_w1_idx", 32'(sIdx[1]), 32'h1);
    check("sw2_scnt", 32'(sCnt[1]), 32'd2);
    check("sw2_done", 32'(dCnt[1]), 32'd1);
    check("sw2_fdata", 32'(fData[1]), 32'h010);

    // fast-only frames (FAST_BYTES=4, SLOW_WORDS=0)
    for (int i = 1; i <= 3; i++) sendByte(2, 8'(i), 3);
    check("f4_nodone", 32'(dCnt[2]), 32'd0);
    sendByte(2, 8'h04, 3);
    check("f4_done", 32'(dCnt[2]), 32'd1);
    check("f4_done_with_f", 32'(dWithF[2]), 32'd1);
    check("f4_fdata", 32'(fData[2]), 32'h020);
    for (int i = 5; i <= 7; i++) sendByte(2, 8'(i), 3);
    check("f4_2nd_nodone", 32'(dCnt[2]), 32'd1);
    sendByte(2, 8'h08, 3);
    check("f4_2nd_done", 32'(dCnt[2]), 32'd2);
    check("f4_fcnt", 32'(fCnt[2]), 32'd8);

    // timeout after 5 bytes
    for (int i = 1; i <= 5; i++) sendByte(0, 8'(i), 3);
    idle(1000);
    check("gap_early", 32'(eCnt[0]), 32'd0);
    idle(100);
    check("gap_err", 32'(eCnt[0]), 32'd1);
    idle(1100);
    check("gap_err_once", 32'(eCnt[0]), 32'd1);
    check("gap_hold_fdata", 32'(fData[0]), 32'h028);
    sendByte(0, 8'h80, 3);
    check("gap_next_fdata", 32'(fData[0]), 32'h400);
    for (int i = 1; i < 16; i++) sendByte(0, 8'(i), 3);
    check("gap_frame_nodone", 32'(dCnt[0]), 32'd2);
    sendByte(0, 8'h55, 3);
    sendByte(0, 8'h02, 3);
    check("gap_frame_done", 32'(dCnt[0]), 32'd3);
    check("gap_frame_sdata", 32'(sData[0]), 32'h4AA);

    // strobe held high for 50 cycles
    baseF = fCnt[0];
    sendByte(0, 8'h12, 50);
    check("held_one_fval", 32'(fCnt[0] - baseF), 32'd1);
    check("held_fdata", 32'(fData[0]), 32'h090);

    // reset mid-frame
    sendByte(0, 8'h34, 3);
    baseF = fCnt[0];
    baseD = dCnt[0];
    baseS = sCnt[0];
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_fdata", 32'(fData[0]), 32'h0);
    check("mid_rst_sdata", 32'(sData[0]), 32'h0);
    idle(2);
    rst = 1'b1;
    idle(3);
    check("mid_rst_nopulse", 32'(fCnt[0] + dCnt[0] + sCnt[0] + eCnt[0] - baseF - baseD - baseS),
          32'(eCnt[0]));
    for (int i = 0; i < 16; i++) sendByte(0, 8'(i), 3);
    check("post_rst_nodone", 32'(dCnt[0] - baseD), 32'd0);
    sendByte(0, 8'h00, 3);
    sendByte(0, 8'h01, 3);
    check("post_rst_done", 32'(dCnt[0] - baseD), 32'd1);
    check("post_rst_sdata", 32'(sData[0]), 32'h200);
    check("post_rst_noerr", 32'(eCnt[0]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
